cordic_arbiter: RTL and testbench

Round-robin scheduler that shares one pipelined CORDIC sine/cosine core (one angle per cycle, fixed latency) among N requesters. It sits between the requesters and the core. It grants at most one angle per cycle, drives the core's angle input, and tracks every issued operation in a tag pipeline. When each result leaves the core, the block returns it to the requester that issued it.

---
 rtl/cordic_arbiter.sv | 113 +++++++++++
 tb/tb_cordic_arbiter.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin front end that shares one pipelined
// CORDIC sin/cos core among N requesters and routes results back.
module cordic_arbiter #(
  parameter int N   = 4,
  parameter int AW  = 20,
  parameter int DW  = 18,
  parameter int LAT = 18
) (
  input  logic            clock,
  input  logic            rstn,
  input  logic [N-1:0]    io_req_valid,
  output logic [N-1:0]    io_req_ready,
  input  logic [N*AW-1:0] io_req_angle,
  output logic [N-1:0]    io_resp_valid,
  output logic [DW-1:0]   io_resp_s,
  output logic [DW-1:0]   io_resp_c,
  output logic [AW-1:0]   io_cordic_a,
  input  logic [DW-1:0]   io_cordic_s,
  input  logic [DW-1:0]   io_cordic_c,
  output logic            io_idle
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = LW + 1;

  typedef struct packed {
    logic          v;
    logic [LW-1:0] id;
  } tag_t;

  logic [LW-1:0]    last_q;
  logic [LW-1:0]    last_d;
  tag_t [LAT-1:0]   tag_q;
  tag_t [LAT-1:0]   tag_d;

  logic             grant_any;
  logic [LW-1:0]    grant_idx;
  logic [CW-1:0]    cand;
  logic [LAT-1:0]   busy;

  // Search last+1, last+2, ... modulo N; first valid wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_q} + CW'(k);
      if (cand >= CW'(N))
        cand = cand - CW'(N);
      if (!grant_any && io_req_valid[cand[LW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[LW-1:0];
      end
    end
    if (!rstn) begin
      grant_any = 1'b0;
      grant_idx = '0;
    end
  end

  always_comb begin
    io_req_ready = '0;
    io_cordic_a  = '0;
    if (grant_any) begin
      io_req_ready[grant_idx] = 1'b1;
      io_cordic_a = io_req_angle[grant_idx*AW +: AW];
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant_any)
      last_d = grant_idx;
  end

  // Bubbles enter as v=0 so the tag line always shifts.
  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = {grant_any, grant_idx};
    for (int i = 1; i < LAT; i++)
      tag_d[i] = tag_q[i-1];
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < LAT; i++)
      busy[i] = tag_q[i].v;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      last_q <= LW'(N - 1);
      tag_q  <= '0;
    end else begin
      last_q <= last_d;
      tag_q  <= tag_d;
    end
  end

  always_comb begin
    io_resp_valid = '0;
    io_resp_s     = '0;
    io_resp_c     = '0;
    if (tag_q[LAT-1].v) begin
      io_resp_valid[tag_q[LAT-1].id] = 1'b1;
      io_resp_s = io_cordic_s;
      io_resp_c = io_cordic_c;
    end
  end

  assign io_idle = !rstn || (!(|busy) && !(|io_req_valid));

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: random and directed stimulus against a
// queue-based model of grants and returned results.
`timescale 1ns/1ps
module tb_cordic_arbiter;

  localparam int  N   = 4;
  localparam int  AW  = 20;
  localparam int  DW  = 18;
  localparam int  LAT = 18;
  localparam real PI  = 3.14159265358979;
  localparam real ONE = 65536.0;

  logic                 clock = 1'b0;
  logic                 rstn  = 1'b0;
  logic [N-1:0]         io_req_valid = '0;
  logic [N-1:0]         io_req_ready;
  logic [N*AW-1:0]      io_req_angle = '0;
  logic [N-1:0]         io_resp_valid;
  logic signed [DW-1:0] io_resp_s;
  logic signed [DW-1:0] io_resp_c;
  logic [AW-1:0]        io_cordic_a;
  logic signed [DW-1:0] io_cordic_s;
  logic signed [DW-1:0] io_cordic_c;
  logic                 io_idle;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  cordic_arbiter #(.N(N), .AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clock         (clock),
    .rstn          (rstn),
    .io_req_valid  (io_req_valid),
    .io_req_ready  (io_req_ready),
    .io_req_angle  (io_req_angle),
    .io_resp_valid (io_resp_valid),
    .io_resp_s     (io_resp_s),
    .io_resp_c     (io_resp_c),
    .io_cordic_a   (io_cordic_a),
    .io_cordic_s   (io_cordic_s),
    .io_cordic_c   (io_cordic_c),
    .io_idle       (io_idle)
  );

  function automatic logic signed [DW-1:0] sin_of(input logic [AW-1:0] a);
    real r;
    r = real'(a) * PI / 262144.0;
    return DW'($rtoi($floor(ONE * $sin(r) + 0.5)));
  endfunction

  function automatic logic signed [DW-1:0] cos_of(input logic [AW-1:0] a);
    real r;
    r = real'(a) * PI / 262144.0;
    return DW'($rtoi($floor(ONE * $cos(r) + 0.5)));
  endfunction

  function automatic logic [AW-1:0] deg(input int d);
    return AW'((d * 131072 + 45) / 90);
  endfunction

  // Behavioural core: LAT-deep angle delay, ideal sin/cos at output.
  logic [AW-1:0] pipe [LAT];
  always @(posedge clock) begin
    pipe[0] <= io_cordic_a;
    for (int i = 1; i < LAT; i++)
      pipe[i] <= pipe[i-1];
  end
  assign io_cordic_s = sin_of(pipe[LAT-1]);
  assign io_cordic_c = cos_of(pipe[LAT-1]);

  typedef struct {
    int id;
    int ang;
    int due;
  } op_t;

  op_t q[$];
  int  last_m = N - 1;
  int  cyc    = 0;

  logic [N-1:0]         e_ready;
  logic [N-1:0]         e_rv;
  logic [AW-1:0]        e_a;
  logic signed [DW-1:0] e_s;
  logic signed [DW-1:0] e_c;
  logic                 e_idle;

  function automatic int pick();
    int j;
    if (!rstn) return -1;
    for (int k = 1; k <= N; k++) begin
      j = (last_m + k) % N;
      if (io_req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic predict();
    int g;
    g = pick();
    e_ready = '0;
    e_a     = '0;
    e_rv    = '0;
    e_s     = '0;
    e_c     = '0;
    if (g >= 0) begin
      e_ready[g] = 1'b1;
      e_a = io_req_angle[g*AW +: AW];
    end
    if (rstn && q.size() > 0 && q[0].due == cyc) begin
      e_rv[q[0].id] = 1'b1;
      e_s = sin_of(AW'(q[0].ang));
      e_c = cos_of(AW'(q[0].ang));
    end
    e_idle = !rstn || (q.size() == 0 && io_req_valid == '0);
  endtask

  task automatic settle();
    #1;
    predict();
  endtask

  task automatic adv();
    int g;
    @(posedge clock);
    g = pick();
    if (!rstn) begin
      q.delete();
      last_m = N - 1;
    end else begin
      if (q.size() > 0 && q[0].due == cyc)
        void'(q.pop_front());
      if (g >= 0) begin
        last_m = g;
        q.push_back('{g, int'(io_req_angle[g*AW +: AW]), cyc + LAT});
      end
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic set_angle(input int i, input logic [AW-1:0] a);
    io_req_angle[i*AW +: AW] = a;
  endtask

  task automatic rand_angles();
    for (int i = 0; i < N; i++)
      set_angle(i, AW'($urandom));
  endtask

  task automatic do_reset();
    io_req_valid = '0;
    rstn = 1'b0;
    adv();
    adv();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    io_req_valid = '1;
    rand_angles();
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (io_req_ready !== 0 || io_cordic_a !== 0 || io_resp_valid !== 0 ||
          io_resp_s !== 0 || io_resp_c !== 0 || io_idle !== 1'b1) begin
        failures++;
        $display("FAIL reset rdy=%b a=%0d rv=%b s=%0d c=%0d idle=%b want all 0, idle 1",
                 io_req_ready, io_cordic_a, io_resp_valid, io_resp_s, io_resp_c, io_idle);
      end
      adv();
    end
    io_req_valid = '0;
    rstn = 1'b1;
  endtask

  task automatic test_single();
    int sv;
    int cv;
    do_reset();
    rand_angles();
    set_angle(0, AW'(43690));
    io_req_valid = 4'b0001;
    settle();
    checks++;
    if (io_req_ready !== 4'b0001 || io_cordic_a !== AW'(43690)) begin
      failures++;
      $display("FAIL single_issue rdy=%b a=%0d want 0001 43690", io_req_ready, io_cordic_a);
    end
    adv();
    io_req_valid = '0;
    for (int i = 1; i <= LAT + 1; i++) begin
      settle();
      checks++;
      if ({io_req_ready, io_cordic_a, io_resp_valid, io_resp_s, io_resp_c, io_idle} !==
          {e_ready, e_a, e_rv, e_s, e_c, e_idle}) begin
        failures++;
        $display("FAIL single cyc=%0d rdy=%b/%b a=%0d/%0d rv=%b/%b s=%0d/%0d c=%0d/%0d idle=%b/%b (got/want)",
                 cyc, io_req_ready, e_ready, io_cordic_a, e_a, io_resp_valid, e_rv,
                 io_resp_s, e_s, io_resp_c, e_c, io_idle, e_idle);
      end
      if (i == LAT) begin
        sv = io_resp_s;
        cv = io_resp_c;
        checks++;
        if (io_resp_valid !== 4'b0001 || sv < 32764 || sv > 32772 ||
            cv < 56752 || cv > 56760) begin
          failures++;
          $display("FAIL single_result rv=%b s=%0d c=%0d want 0001 32768 56756",
                   io_resp_valid, sv, cv);
        end
      end
      if (i == LAT + 1) begin
        checks++;
        if (io_idle !== 1'b1 || io_resp_valid !== 0) begin
          failures++;
          $display("FAIL single_idle idle=%b rv=%b want 1 0000", io_idle, io_resp_valid);
        end
      end
      adv();
    end
  endtask

  task automatic test_all_four();
    int cv;
    logic [N-1:0] want;
    do_reset();
    for (int i = 0; i < N; i++)
      set_angle(i, deg(45 * i));
    io_req_valid = '1;
    for (int i = 0; i < LAT + 16; i++) begin
      settle();
      checks++;
      if ({io_req_ready, io_cordic_a, io_resp_valid, io_resp_s, io_resp_c, io_idle} !==
          {e_ready, e_a, e_rv, e_s, e_c, e_idle}) begin
        failures++;
        $display("FAIL all_four cyc=%0d rdy=%b/%b a=%0d/%0d rv=%b/%b s=%0d/%0d c=%0d/%0d idle=%b/%b (got/want)",
                 cyc, io_req_ready, e_ready, io_cordic_a, e_a, io_resp_valid, e_rv,
                 io_resp_s, e_s, io_resp_c, e_c, io_idle, e_idle);
      end
      want = N'(1) << (i % N);
      checks++;
      if (io_req_ready !== want) begin
        failures++;
        $display("FAIL all_four_order i=%0d rdy=%b want %b", i, io_req_ready, want);
      end
      if (i >= LAT) begin
        want = N'(1) << ((i - LAT) % N);
        cv = io_resp_c;
        checks++;
        if (io_resp_valid !== want ||
            ((i - LAT) % N == 2 && (io_resp_s !== DW'(65536) || cv < -4 || cv > 4))) begin
          failures++;
          $display("FAIL all_four_resp i=%0d rv=%b want %b s=%0d c=%0d",
                   i, io_resp_valid, want, io_resp_s, cv);
        end
      end
      adv();
    end
    io_req_valid = '0;
  endtask

  task automatic test_pair();
    logic [N-1:0] want;
    do_reset();
    rand_angles();
    io_req_valid = 4'b0010;
    settle();
    adv();
    io_req_valid = 4'b1010;
    for (int i = 0; i < LAT + 14; i++) begin
      if (i == 12) io_req_valid = '0;
      if (i < 12) rand_angles();
      settle();
      checks++;
      if ({io_req_ready, io_cordic_a, io_resp_valid, io_resp_s, io_resp_c, io_idle} !==
          {e_ready, e_a, e_rv, e_s, e_c, e_idle}) begin
        failures++;
        $display("FAIL pair cyc=%0d rdy=%b/%b a=%0d/%0d rv=%b/%b s=%0d/%0d c=%0d/%0d idle=%b/%b (got/want)",
                 cyc, io_req_ready, e_ready, io_cordic_a, e_a, io_resp_valid, e_rv,
                 io_resp_s, e_s, io_resp_c, e_c, io_idle, e_idle);
      end
      if (i < 12) begin
        want = (i % 2 == 0) ? 4'b1000 : 4'b0010;
        checks++;
        if (io_req_ready !== want) begin
          failures++;
          $display("FAIL pair_order i=%0d rdy=%b want %b", i, io_req_ready, want);
        end
      end
      adv();
    end
  endtask

  task automatic test_burst();
    int grants;
    int pulses;
    int first;
    int lastp;
    grants = 0;
    pulses = 0;
    first  = -1;
    lastp  = -1;
    for (int i = 0; i < LAT + 8; i++) begin
      io_req_valid = (i < 5) ? 4'b0100 : 4'b0000;
      rand_angles();
      settle();
      checks++;
      if ({io_req_ready, io_cordic_a, io_resp_valid, io_resp_s, io_resp_c, io_idle} !==
          {e_ready, e_a, e_rv, e_s, e_c, e_idle}) begin
        failures++;
        $display("FAIL burst cyc=%0d rdy=%b/%b a=%0d/%0d rv=%b/%b s=%0d/%0d c=%0d/%0d idle=%b/%b (got/want)",
                 cyc, io_req_ready, e_ready, io_cordic_a, e_a, io_resp_valid, e_rv,
                 io_resp_s, e_s, io_resp_c, e_c, io_idle, e_idle);
      end
      if (io_req_ready == 4'b0100) grants++;
      if (io_resp_valid == 4'b0100) begin
        pulses++;
        if (first < 0) first = i;
        lastp = i;
      end
      adv();
    end
    checks++;
    if (grants != 5 || pulses != 5 || first != LAT || lastp != LAT + 4) begin
      failures++;
      $display("FAIL burst_count grants=%0d pulses=%0d span=%0d..%0d want 5 5 %0d..%0d",
               grants, pulses, first, lastp, LAT, LAT + 4);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    do_reset();
    io_req_valid = '1;
    for (int i = 0; i < 6; i++) begin
      rand_angles();
      settle();
      adv();
    end
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (io_idle !== 1'b1 || io_req_ready !== 0 || io_resp_valid !== 0 ||
          io_cordic_a !== 0) begin
        failures++;
        $display("FAIL midreset_hold idle=%b rdy=%b rv=%b a=%0d want 1 0 0 0",
                 io_idle, io_req_ready, io_resp_valid, io_cordic_a);
      end
      adv();
    end
    rstn = 1'b1;
    settle();
    checks++;
    if (io_req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midreset_first rdy=%b want 0001", io_req_ready);
    end
    adv();
    io_req_valid = '0;
    for (int i = 0; i < LAT + 3; i++) begin
      settle();
      checks++;
      if ({io_req_ready, io_cordic_a, io_resp_valid, io_resp_s, io_resp_c, io_idle} !==
          {e_ready, e_a, e_rv, e_s, e_c, e_idle}) begin
        failures++;
        $display("FAIL midreset cyc=%0d rdy=%b/%b a=%0d/%0d rv=%b/%b s=%0d/%0d c=%0d/%0d idle=%b/%b (got/want)",
                 cyc, io_req_ready, e_ready, io_cordic_a, e_a, io_resp_valid, e_rv,
                 io_resp_s, e_s, io_resp_c, e_c, io_idle, e_idle);
      end
      if (io_resp_valid != 0) pulses++;
      adv();
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL midreset_drop pulses=%0d want 1", pulses);
    end
  endtask

  task automatic test_sweep();
    int     cnt;
    int     gaps;
    longint ls;
    longint lc;
    longint err;
    cnt  = 0;
    gaps = 0;
    for (int i = 0; i < 360 + LAT + 1; i++) begin
      io_req_valid = (i < 360) ? 4'b0010 : 4'b0000;
      if (i < 360) set_angle(1, deg(i));
      settle();
      checks++;
      if ({io_req_ready, io_cordic_a, io_resp_valid, io_resp_s, io_resp_c, io_idle} !==
          {e_ready, e_a, e_rv, e_s, e_c, e_idle}) begin
        failures++;
        $display("FAIL sweep cyc=%0d rdy=%b/%b a=%0d/%0d rv=%b/%b s=%0d/%0d c=%0d/%0d idle=%b/%b (got/want)",
                 cyc, io_req_ready, e_ready, io_cordic_a, e_a, io_resp_valid, e_rv,
                 io_resp_s, e_s, io_resp_c, e_c, io_idle, e_idle);
      end
      if (io_resp_valid != 0) begin
        cnt++;
        ls  = io_resp_s;
        lc  = io_resp_c;
        err = ls * ls + lc * lc - 64'sd4294967296;
        if (err < 0) err = -err;
        checks++;
        if (err > 64'sd4294967) begin
          failures++;
          $display("FAIL sweep_norm i=%0d s=%0d c=%0d err=%0d want <= 4294967",
                   i, ls, lc, err);
        end
      end
      if (i >= LAT && i < LAT + 360 && io_resp_valid !== 4'b0010) gaps++;
      adv();
    end
    checks++;
    if (cnt != 360 || gaps != 0) begin
      failures++;
      $display("FAIL sweep_count resp=%0d gaps=%0d want 360 0", cnt, gaps);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      io_req_valid = (i < 380) ? N'($urandom) : '0;
      rand_angles();
      settle();
      checks++;
      if ({io_req_ready, io_cordic_a, io_resp_valid, io_resp_s, io_resp_c, io_idle} !==
          {e_ready, e_a, e_rv, e_s, e_c, e_idle}) begin
        failures++;
        $display("FAIL random cyc=%0d rdy=%b/%b a=%0d/%0d rv=%b/%b s=%0d/%0d c=%0d/%0d idle=%b/%b (got/want)",
                 cyc, io_req_ready, e_ready, io_cordic_a, e_a, io_resp_valid, e_rv,
                 io_resp_s, e_s, io_resp_c, e_c, io_idle, e_idle);
      end
      adv();
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single();
    test_all_four();
    test_pair();
    test_burst();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
